// File: rtl/window_integrator.sv
// window_integrator: integrates a signed ADC sample stream over framed windows
// and emits one result record per window (sum, count, min, max, flags) on a
// single-entry valid/ready output register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data               signed sample
//   in_active/in_valid    window in progress / sample qualifies
//   in_first/in_last      window start / end markers
//   out_valid/out_ready   result record handshake
//   out_sum/out_num       signed sum and count of valid samples
//   out_min/out_max       extreme samples (0 for an empty window)
//   out_ovf/out_trunc     sum overflowed / window closed without in_last
//   lost_cnt              saturating count of records dropped on backpressure
//   out_sumsq             sum of squares (only with WINDOW_INTEGRATOR_SUMSQ_EN)
//
// Optional feature macro: WINDOW_INTEGRATOR_SUMSQ_EN adds out_sumsq.
module window_integrator #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned SUM_W  = 48,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LOST_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_active,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]         out_num,
  output logic signed [DATA_W-1:0] out_min,
  output logic signed [DATA_W-1:0] out_max,
  output logic                     out_ovf,
  output logic                     out_trunc,
`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
  output logic [2*DATA_W+CNT_W-1:0] out_sumsq,
`endif
  output logic [LOST_W-1:0]        lost_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]               state_q, state_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]         num_q, num_d;
  logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic                     ovf_q, ovf_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]         out_num_q, out_num_d;
  logic signed [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
  logic                     out_ovf_q, out_ovf_d, out_trunc_q, out_trunc_d;
  logic [LOST_W-1:0]        lost_q, lost_d;

  logic                     in_accum, trunc_first, trunc_idle, win_on, take;
  logic                     rec_acc, close, drop_new, load;
  logic signed [SUM_W-1:0]  base_sum, data_ext, add_sum, upd_sum;
  logic [CNT_W-1:0]         base_num, upd_num;
  logic signed [DATA_W-1:0] base_min, base_max, upd_min, upd_max;
  logic                     base_ovf, add_ovf, upd_ovf;
  logic [1:0]               lost_inc;
  logic [LOST_W:0]          lost_sum;

`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
  localparam int unsigned PR_W = 2 * DATA_W;
  localparam int unsigned SQ_W = 2 * DATA_W + CNT_W;
  logic [SQ_W-1:0]          sumsq_q, sumsq_d, out_sumsq_q, out_sumsq_d;
  logic [SQ_W-1:0]          cur_sumsq, base_sumsq;
  logic [PR_W-1:0]          sq_q, sq_d, sq_now;
  logic signed [PR_W-1:0]   dext;
  logic                     sq_vld_q, sq_vld_d;
`endif

  // Framing decode, window accumulation and result/output register next state
  always_comb begin
    in_accum    = (state_q == S_ACCUM);
    trunc_first = in_accum && in_first;
    trunc_idle  = in_accum && !in_first && !in_last && !in_active;
    win_on      = in_first || (in_accum && (in_active || in_last));
    take        = win_on && in_valid;
    // Truncated closes report the window as it stood before this cycle's sample
    rec_acc     = trunc_first || trunc_idle;
    close       = rec_acc || (win_on && in_last);
    // first+last mid-window: the old window takes the slot, the one-cycle window is lost
    drop_new    = trunc_first && in_last;

    base_sum = in_first ? '0 : sum_q;
    base_num = in_first ? '0 : num_q;
    base_min = in_first ? '0 : min_q;
    base_max = in_first ? '0 : max_q;
    base_ovf = in_first ? 1'b0 : ovf_q;

    data_ext = SUM_W'(in_data);
    add_sum  = base_sum + data_ext;
    add_ovf  = (base_sum[SUM_W-1] == data_ext[SUM_W-1]) &&
               (add_sum[SUM_W-1] != base_sum[SUM_W-1]);

    upd_sum = base_sum;
    upd_num = base_num;
    upd_min = base_min;
    upd_max = base_max;
    upd_ovf = base_ovf;
    if (take) begin
      upd_sum = add_sum;
      upd_ovf = base_ovf | add_ovf;
      if (!(&base_num)) upd_num = base_num + CNT_W'(1);
      if (base_num == '0) begin
        upd_min = in_data;
        upd_max = in_data;
      end else begin
        if (in_data < base_min) upd_min = in_data;
        if (in_data > base_max) upd_max = in_data;
      end
    end

    state_d = (win_on && !in_last) ? S_ACCUM : S_IDLE;
    sum_d   = '0;
    num_d   = '0;
    min_d   = '0;
    max_d   = '0;
    ovf_d   = 1'b0;
    if (state_d == S_ACCUM) begin
      sum_d = upd_sum;
      num_d = upd_num;
      min_d = upd_min;
      max_d = upd_max;
      ovf_d = upd_ovf;
    end

    // Single-entry output: a handshake frees the slot in the same cycle
    load        = close && !(out_valid_q && !out_ready);
    out_valid_d = out_valid_q && !out_ready;
    out_sum_d   = out_sum_q;
    out_num_d   = out_num_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_sum_d   = rec_acc ? sum_q : upd_sum;
      out_num_d   = rec_acc ? num_q : upd_num;
      out_min_d   = rec_acc ? min_q : upd_min;
      out_max_d   = rec_acc ? max_q : upd_max;
      out_ovf_d   = rec_acc ? ovf_q : upd_ovf;
      out_trunc_d = rec_acc;
    end

    lost_inc = 2'(close && out_valid_q && !out_ready) + 2'(drop_new);
    lost_sum = (LOST_W+1)'(lost_q) + (LOST_W+1)'(lost_inc);
    lost_d   = lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];

`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
    // Previous sample's square is held one cycle and folded into the running sum
    dext       = PR_W'(in_data);
    sq_now     = dext * dext;
    cur_sumsq  = sumsq_q + (sq_vld_q ? SQ_W'(sq_q) : '0);
    base_sumsq = in_first ? '0 : cur_sumsq;
    sumsq_d    = '0;
    sq_d       = '0;
    sq_vld_d   = 1'b0;
    if (state_d == S_ACCUM) begin
      sumsq_d  = base_sumsq;
      sq_d     = take ? sq_now : '0;
      sq_vld_d = take;
    end
    out_sumsq_d = out_sumsq_q;
    if (load) out_sumsq_d = rec_acc ? cur_sumsq
                                    : base_sumsq + (take ? SQ_W'(sq_now) : '0);
`endif
  end

  // State, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      num_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_num_q   <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
      lost_q      <= '0;
`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
      sumsq_q     <= '0;
      sq_q        <= '0;
      sq_vld_q    <= 1'b0;
      out_sumsq_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      num_q       <= num_d;
      min_q       <= min_d;
      max_q       <= max_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_num_q   <= out_num_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
      lost_q      <= lost_d;
`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
      sumsq_q     <= sumsq_d;
      sq_q        <= sq_d;
      sq_vld_q    <= sq_vld_d;
      out_sumsq_q <= out_sumsq_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_num   = out_num_q;
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;
  assign lost_cnt  = lost_q;
`ifdef WINDOW_INTEGRATOR_SUMSQ_EN
  assign out_sumsq = out_sumsq_q;
`endif

endmodule

// File: tb/tb_window_integrator.sv
// Scoreboard bench for window_integrator: two instances (default and SUM_W=20)
// share one stimulus stream; each has its own expected-record queue and monitor.
module tb_window_integrator;

  localparam int unsigned DW  = 18;
  localparam int unsigned SW  = 48;
  localparam int unsigned SW2 = 20;
  localparam int unsigned CW  = 32;
  localparam int unsigned LW  = 16;

  logic clk;
  logic rst_n;
  logic signed [DW-1:0] in_data;
  logic in_active, in_valid, in_first, in_last, out_ready;

  logic v1, ovf1, tr1;
  logic signed [SW-1:0] sum1;
  logic [CW-1:0] num1;
  logic signed [DW-1:0] min1, max1;
  logic [LW-1:0] lost1;

  logic v2, ovf2, tr2;
  logic signed [SW2-1:0] sum2;
  logic [CW-1:0] num2;
  logic signed [DW-1:0] min2, max2;
  logic [LW-1:0] lost2;

  window_integrator #(.DATA_W(DW), .SUM_W(SW), .CNT_W(CW), .LOST_W(LW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_active(in_active),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .out_valid(v1), .out_ready(out_ready), .out_sum(sum1), .out_num(num1),
    .out_min(min1), .out_max(max1), .out_ovf(ovf1), .out_trunc(tr1),
    .lost_cnt(lost1)
  );

  window_integrator #(.DATA_W(DW), .SUM_W(SW2), .CNT_W(CW), .LOST_W(LW)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_active(in_active),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .out_valid(v2), .out_ready(out_ready), .out_sum(sum2), .out_num(num2),
    .out_min(min2), .out_max(max2), .out_ovf(ovf2), .out_trunc(tr2),
    .lost_cnt(lost2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    longint num;
    longint mn;
    longint mx;
    bit     ovf;
    bit     trunc;
    longint sum20;
    bit     ovf20;
  } rec_t;

  rec_t q1[$];
  rec_t q2[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input longint s, input longint n, input longint mn,
                      input longint mx, input bit o, input bit t,
                      input longint s20, input bit o20);
    rec_t r;
    r.sum = s; r.num = n; r.mn = mn; r.mx = mx; r.ovf = o; r.trunc = t;
    r.sum20 = s20; r.ovf20 = o20;
    q1.push_back(r);
    q2.push_back(r);
  endtask

  // Records whose sum fits both accumulator widths
  task automatic exp_rec(input longint s, input longint n, input longint mn,
                         input longint mx, input bit t);
    push(s, n, mn, mx, 1'b0, t, s, 1'b0);
  endtask

  task automatic drive(input bit f, input bit l, input bit a, input bit v, input int d);
    in_first = f; in_last = l; in_active = a; in_valid = v; in_data = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: a record is consumed when out_valid and out_ready meet at the next edge
  always @(negedge clk) begin
    rec_t e;
    if (rst_n && v1 && out_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i1_unexpected: got record sum %0d, expected none", sum1);
      end else begin
        e = q1.pop_front();
        chk("i1_sum", sum1, e.sum);
        chk("i1_num", num1, e.num);
        chk("i1_min", min1, e.mn);
        chk("i1_max", max1, e.mx);
        chk("i1_ovf", ovf1, e.ovf);
        chk("i1_trunc", tr1, e.trunc);
      end
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (rst_n && v2 && out_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i2_unexpected: got record sum %0d, expected none", sum2);
      end else begin
        e = q2.pop_front();
        chk("i2_sum", sum2, e.sum20);
        chk("i2_num", num2, e.num);
        chk("i2_min", min2, e.mn);
        chk("i2_max", max2, e.mx);
        chk("i2_ovf", ovf2, e.ovf20);
        chk("i2_trunc", tr2, e.trunc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    in_data = '0; in_active = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", v1, 0);
    chk("rst_sum", sum1, 0);
    chk("rst_num", num1, 0);
    chk("rst_min", min1, 0);
    chk("rst_max", max1, 0);
    chk("rst_lost", lost1, 0);
    chk("rst_valid2", v2, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic window: first without sample, then 5,-3,10 with last on the 10
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 5);
    drive(0, 0, 1, 1, -3);
    chk("t1_not_early", v1, 0);
    exp_rec(12, 3, -3, 10, 0);
    drive(0, 1, 1, 1, 10);
    chk("t1_latency", v1, 1);
    idle();

    // One-cycle window
    exp_rec(-7, 1, -7, -7, 0);
    drive(1, 1, 1, 1, -7);
    idle();

    // Empty window of four cycles
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    exp_rec(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    idle();

    // Restart mid-window: 1,2 truncated, new window 4,8
    drive(1, 0, 1, 1, 1);
    drive(0, 0, 1, 1, 2);
    exp_rec(3, 2, 1, 2, 1);
    drive(1, 0, 1, 1, 4);
    exp_rec(12, 2, 4, 8, 0);
    drive(0, 1, 1, 1, 8);
    idle();

    // Framing drops without last
    drive(1, 0, 1, 1, 6);
    drive(0, 0, 1, 1, -2);
    exp_rec(4, 2, -2, 6, 1);
    idle();
    idle();

    // Backpressure: first record held, two further closes lost
    out_ready = 1'b0;
    exp_rec(3, 1, 3, 3, 0);
    drive(1, 1, 1, 1, 3);
    idle();
    drive(1, 1, 1, 1, 100);
    drive(1, 0, 1, 1, 50);
    drive(0, 1, 1, 1, -50);
    idle();
    chk("bp_lost", lost1, 2);
    chk("bp_lost2", lost2, 2);
    chk("bp_held_valid", v1, 1);
    chk("bp_held_sum", sum1, 3);
    chk("bp_held_num", num1, 1);
    out_ready = 1'b1;
    exp_rec(-9, 1, -9, -9, 0);
    drive(1, 1, 1, 1, -9);
    out_ready = 1'b0;
    chk("bp_reload_valid", v1, 1);
    chk("bp_reload_sum", sum1, -9);
    chk("bp_reload_lost", lost1, 2);
    idle();
    out_ready = 1'b1;
    idle();
    idle();

    // Accumulator overflow in the 20-bit instance only
    drive(1, 0, 1, 1, 131071);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, 131071);
    push(1179639, 9, 131071, 131071, 1'b0, 1'b0, 131063, 1'b1);
    drive(0, 1, 1, 1, 131071);
    idle();
    idle();

    // Reset while a record is pending and a window is open
    out_ready = 1'b0;
    drive(1, 1, 1, 1, 7);
    drive(1, 0, 1, 1, 8);
    drive(0, 0, 1, 1, 9);
    chk("mr_pending", v1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", v1, 0);
    chk("mr_valid2", v2, 0);
    chk("mr_lost", lost1, 0);
    chk("mr_sum", sum1, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(0, 1, 1, 1, 5);
    idle();
    idle();
    chk("mr_no_record", v1, 0);
    chk("mr_no_record2", v2, 0);
    idle();

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
